// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared fetch-unit state encoding, fault causes and NOP word
package riscv_fetch_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;
  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: instruction memory read bus (master = fetch unit: mem_req/mem_addr out, mem_ready/mem_rdata in)
interface ifetch_unit_if #(parameter int XLEN = 32);
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;
  modport master (output mem_req, mem_addr, input mem_ready, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ready, mem_rdata);
endinterface

// File: rtl/fetch_timeout.sv
// fetch_timeout: saturating wait counter (clk, rst, clr, inc in; expired out when this increment reaches LIMIT)
module fetch_timeout #(
  parameter int LIMIT = 15,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != W'(LIMIT)) cnt <= cnt + 1'b1;
  // combinational so the fault lands the cycle right after the last waited cycle
  always_comb expired = inc && cnt >= W'(LIMIT - 1);
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch FSM (clk, rst, fetch_start/pc_in/flush/instr_ack in; mem bus; instr/instr_pc/instr_valid/busy/fault/fault_cause out)
module ifetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TIMEOUT = 15,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_start,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  input  logic            instr_ack,
  ifetch_unit_if.master   mem,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  output logic            busy,
  output logic            fault,
  output logic [1:0]      fault_cause
);
  fetch_state_t state, state_n;
  logic misal, accept, waiting, expired;
  always_comb begin
    misal   = |pc_in[1:0];
    accept  = fetch_start && !busy && !flush;
    waiting = state == REQ && !mem.mem_ready;
  end
  fetch_timeout #(.LIMIT(TIMEOUT)) u_timeout (
    .clk(clk), .rst(rst), .clr(accept && !misal), .inc(waiting), .expired(expired)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // accept only happens in IDLE or HOLD with ack, so it covers both fetch entry paths
  always_comb
    state_n = flush ? IDLE
            : accept ? (misal ? FAULT : REQ)
            : (state == REQ && mem.mem_ready) ? HOLD
            : expired ? FAULT
            : (state == HOLD && instr_ack) ? IDLE
            : state;
  always_comb begin
    mem.mem_req = state == REQ;
    instr_valid = state == HOLD;
    fault       = state == FAULT;
    busy        = state != IDLE && !(state == HOLD && instr_ack);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem.mem_addr <= '0;
      instr        <= NOP_INSTR;
      instr_pc     <= '0;
      fault_cause  <= FC_NONE;
    end else begin
      if (accept && !misal) mem.mem_addr <= pc_in;
      if (accept) instr_pc <= pc_in;
      if (!flush && state == REQ && mem.mem_ready) instr <= mem.mem_rdata;
      fault_cause <= flush ? FC_NONE
                   : (accept && misal) ? FC_MISALIGN
                   : expired ? FC_TIMEOUT
                   : fault_cause;
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scoreboard bench for ifetch_unit
module tb_ifetch_unit;
  typedef struct packed {
    logic [31:0] w;
    logic [31:0] pc;
  } exp_t;
  logic clk = 0, rst = 1;
  logic fetch_start = 0, flush = 0, instr_ack = 0;
  logic [31:0] pc_in = 0;
  logic [31:0] instr, instr_pc;
  logic instr_valid, busy, fault;
  logic [1:0] fault_cause;
  int total = 0, passed = 0, fails = 0;
  exp_t sb[$];
  ifetch_unit_if #(.XLEN(32)) bus ();
  ifetch_unit #(.XLEN(32), .TIMEOUT(15), .NOP_INSTR(32'h13)) dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc_in(pc_in), .flush(flush),
    .instr_ack(instr_ack), .mem(bus.master), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .busy(busy), .fault(fault), .fault_cause(fault_cause)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic fetch_go(input logic [31:0] a);
    fetch_start = 1;
    pc_in = a;
    step();
    fetch_start = 0;
  endtask
  task automatic respond(input logic [31:0] d, input logic [31:0] a);
    bus.mem_ready = 1;
    bus.mem_rdata = d;
    sb.push_back('{w: d, pc: a});
    step();
    bus.mem_ready = 0;
  endtask
  task automatic check_pop(input string tag);
    exp_t e;
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    chk({tag, "_sb_nonempty"}, {31'b0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_instr"}, instr, e.w);
      chk({tag, "_pc"}, instr_pc, e.pc);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bus.mem_ready = 0;
    bus.mem_rdata = 0;
    step();
    chk("rst_req", {31'b0, bus.mem_req}, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_pc", instr_pc, 0);
    chk("rst_flags", {28'b0, instr_valid, busy, fault, 1'b0}, 0);
    chk("rst_cause", {30'b0, fault_cause}, 0);
    rst = 0;
    step();
    // zero-wait read
    fetch_go(32'h100);
    chk("zw_req", {31'b0, bus.mem_req}, 1);
    chk("zw_addr", bus.mem_addr, 32'h100);
    chk("zw_busy", {31'b0, busy}, 1);
    respond(32'h0050_0093, 32'h100);
    chk("zw_req_drop", {31'b0, bus.mem_req}, 0);
    check_pop("zw");
    step();
    step();
    chk("zw_hold_valid", {31'b0, instr_valid}, 1);
    chk("zw_hold_instr", instr, 32'h0050_0093);
    instr_ack = 1;
    #1;
    chk("zw_ack_busy", {31'b0, busy}, 0);
    step();
    instr_ack = 0;
    chk("zw_after_ack", {30'b0, instr_valid, busy}, 0);
    // wait states then back-to-back
    fetch_go(32'h100);
    for (int i = 0; i < 3; i++) begin
      chk("ws_req", {31'b0, bus.mem_req}, 1);
      chk("ws_addr", bus.mem_addr, 32'h100);
      step();
    end
    respond(32'h00A0_0113, 32'h100);
    check_pop("ws");
    instr_ack = 1;
    fetch_start = 1;
    pc_in = 32'h104;
    step();
    instr_ack = 0;
    fetch_start = 0;
    chk("b2b_req", {31'b0, bus.mem_req}, 1);
    chk("b2b_addr", bus.mem_addr, 32'h104);
    chk("b2b_valid", {31'b0, instr_valid}, 0);
    respond(32'h00B0_0193, 32'h104);
    check_pop("b2b");
    instr_ack = 1;
    step();
    instr_ack = 0;
    // misaligned
    fetch_go(32'h102);
    chk("mis_fault", {31'b0, fault}, 1);
    chk("mis_cause", {30'b0, fault_cause}, 32'd1);
    chk("mis_busy", {31'b0, busy}, 1);
    chk("mis_pc", instr_pc, 32'h102);
    fetch_start = 1;
    pc_in = 32'h200;
    for (int i = 0; i < 3; i++) begin
      chk("mis_noreq", {31'b0, bus.mem_req}, 0);
      step();
    end
    fetch_start = 0;
    chk("mis_still_fault", {31'b0, fault}, 1);
    flush = 1;
    step();
    flush = 0;
    chk("mis_flush", {29'b0, fault, busy, bus.mem_req}, 0);
    chk("mis_flush_cause", {30'b0, fault_cause}, 0);
    // timeout
    fetch_go(32'h200);
    n = 0;
    while (bus.mem_req && n < 40) begin
      n++;
      step();
    end
    chk("to_req_cycles", n, 15);
    chk("to_fault", {31'b0, fault}, 1);
    chk("to_cause", {30'b0, fault_cause}, 32'd2);
    flush = 1;
    step();
    flush = 0;
    chk("to_flush", {31'b0, fault}, 0);
    fetch_go(32'h204);
    for (int i = 0; i < 14; i++) step();
    chk("to_last_req", {31'b0, bus.mem_req}, 1);
    respond(32'h00C0_0213, 32'h204);
    check_pop("to_late");
    chk("to_late_nofault", {31'b0, fault}, 0);
    instr_ack = 1;
    step();
    instr_ack = 0;
    // flush races
    fetch_go(32'h300);
    flush = 1;
    bus.mem_ready = 1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    flush = 0;
    bus.mem_ready = 0;
    chk("fr_valid", {31'b0, instr_valid}, 0);
    chk("fr_req", {31'b0, bus.mem_req}, 0);
    chk("fr_instr", instr, 32'h00C0_0213);
    flush = 1;
    fetch_start = 1;
    pc_in = 32'h400;
    step();
    flush = 0;
    fetch_start = 0;
    chk("fs_req", {31'b0, bus.mem_req}, 0);
    chk("fs_busy", {31'b0, busy}, 0);
    step();
    chk("fs_req2", {31'b0, bus.mem_req}, 0);
    // async reset mid-request
    fetch_go(32'h500);
    chk("ar_req_pre", {31'b0, bus.mem_req}, 1);
    #2 rst = 1;
    #1;
    chk("ar_req_async", {31'b0, bus.mem_req}, 0);
    step();
    rst = 0;
    step();
    chk("ar_instr", instr, 32'h13);
    chk("ar_valid", {31'b0, instr_valid}, 0);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
